// File: rtl/dev_pkg.sv
// ============================================================================
// dev_pkg : link states, detector bit indices and safe detector view
// Rev 1.0
// ============================================================================
`default_nettype none

package dev_pkg;

   localparam logic [1:0] LINK_DOWN = 2'd0;
   localparam logic [1:0] SYNC      = 2'd1;
   localparam logic [1:0] LINK_UP   = 2'd2;

   localparam int DET_FRONT = 0;
   localparam int DET_LEFT  = 1;
   localparam int DET_RIGHT = 2;
   localparam int DET_BACK  = 3;

   localparam logic [3:0] DET_SAFE = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/det_bit_debounce.sv
// ============================================================================
// det_bit_debounce : per-bit candidate plus saturating match counter
// Rev 1.0
// ============================================================================
`default_nettype none

module det_bit_debounce #(
   parameter int unsigned STABLE_CNT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_seed,
   input  logic i_update,
   input  logic i_bit,
   output logic o_cand,
   output logic o_ready
);

   localparam logic [3:0] C_STABLE = 4'(STABLE_CNT);

   logic       r_cand;
   logic [3:0] r_cnt;

   // A seed always restarts the run, regardless of the current candidate
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cand <= 1'b1;
         r_cnt  <= 4'd0;
      end else if (i_seed || (i_update && (i_bit != r_cand))) begin
         r_cand <= i_bit;
         r_cnt  <= 4'd1;
      end else if (i_update && (r_cnt < C_STABLE)) begin
         r_cnt  <= r_cnt + 4'd1;
      end
   end

   assign o_cand  = r_cand;
   assign o_ready = (r_cnt == C_STABLE);

endmodule

`default_nettype wire

// File: rtl/detector_filter.sv
// ============================================================================
// detector_filter : header check, per-bit debounce and link supervision.
// Optional statistics counters enabled by DETECTOR_FILTER_STATS_EN. Rev 1.0
// ============================================================================
`default_nettype none

module detector_filter
   import dev_pkg::*;
#(
   parameter logic [3:0]  FRAME_HDR   = 4'b0000,
   parameter int unsigned STABLE_CNT  = 3,
   parameter int unsigned TIMEOUT_CYC = 10_000_000,
   parameter int unsigned ERR_LIMIT   = 4
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic [7:0]  rec_byte,
   input  logic        rec_valid,
   output logic [3:0]  det_stable,
   output logic [3:0]  det_rise,
   output logic [3:0]  det_fall,
   output logic        link_ok,
   output logic [15:0] frame_cnt,
   output logic [15:0] err_cnt
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int EW = $clog2(ERR_LIMIT + 1);
   localparam logic [TW-1:0] C_TMAX     = TW'(TIMEOUT_CYC - 1);
   localparam logic [EW-1:0] C_ERR_LAST = EW'(ERR_LIMIT - 1);

   logic [1:0]    r_state;
   logic [1:0]    w_state_next;
   logic [TW-1:0] r_timer;
   logic [EW-1:0] r_err;
   logic [3:0]    r_stable;
   logic [3:0]    r_rise;
   logic [3:0]    r_fall;
   logic [3:0]    w_stable_next;
   logic [3:0]    w_cand;
   logic [3:0]    w_ready;

   logic w_valid, w_bad, w_expire, w_err_hit, w_drop, w_seed, w_update, w_all_ready;

   assign w_valid     = rec_valid && (rec_byte[7:4] == FRAME_HDR);
   assign w_bad       = rec_valid && (rec_byte[7:4] != FRAME_HDR);
   // A valid frame arriving on the expiry cycle reloads the timer instead
   assign w_expire    = (r_timer == C_TMAX) && !w_valid;
   assign w_err_hit   = w_bad && (r_err == C_ERR_LAST);
   assign w_drop      = (r_state != LINK_DOWN) && (w_expire || w_err_hit);
   assign w_seed      = (r_state == LINK_DOWN) && w_valid;
   assign w_update    = (r_state != LINK_DOWN) && w_valid;
   assign w_all_ready = &w_ready;

   for (genvar i = DET_FRONT; i <= DET_BACK; i++) begin : g_bit
      det_bit_debounce #(
         .STABLE_CNT (STABLE_CNT)
      ) u_deb (
         .clk      (sys_clk),
         .rst      (rst),
         .i_clear  (w_drop),
         .i_seed   (w_seed),
         .i_update (w_update),
         .i_bit    (rec_byte[i]),
         .o_cand   (w_cand[i]),
         .o_ready  (w_ready[i])
      );
   end

   always_comb begin
      w_state_next  = r_state;
      w_stable_next = DET_SAFE;
      case (r_state)
         LINK_DOWN: begin
            if (w_seed) w_state_next = SYNC;
         end
         SYNC: begin
            if (w_drop) begin
               w_state_next = LINK_DOWN;
            end else if (w_all_ready) begin
               w_state_next  = LINK_UP;
               w_stable_next = w_cand;
            end
         end
         LINK_UP: begin
            if (w_drop) begin
               w_state_next = LINK_DOWN;
            end else begin
               for (int i = 0; i < 4; i++)
                  w_stable_next[i] = w_ready[i] ? w_cand[i] : r_stable[i];
            end
         end
         default: w_state_next = LINK_DOWN;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state  <= LINK_DOWN;
         r_stable <= DET_SAFE;
         r_rise   <= 4'd0;
         r_fall   <= 4'd0;
      end else begin
         r_state  <= w_state_next;
         r_stable <= w_stable_next;
         r_rise   <= w_stable_next & ~r_stable;
         r_fall   <= ~w_stable_next & r_stable;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst || (r_state == LINK_DOWN) || w_valid || w_drop)
         r_timer <= '0;
      else
         r_timer <= r_timer + 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (rst || w_err_hit || w_valid)
         r_err <= '0;
      else if (w_bad)
         r_err <= r_err + 1'b1;
   end

   assign det_stable = r_stable;
   assign det_rise   = r_rise;
   assign det_fall   = r_fall;
   assign link_ok    = (r_state == LINK_UP);

`ifdef DETECTOR_FILTER_STATS_EN
   logic [15:0] r_frame_cnt;
   logic [15:0] r_err_cnt;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_frame_cnt <= 16'h0000;
         r_err_cnt   <= 16'h0000;
      end else begin
         if (w_valid && (r_frame_cnt != 16'hFFFF)) r_frame_cnt <= r_frame_cnt + 16'd1;
         if (w_bad && (r_err_cnt != 16'hFFFF))     r_err_cnt   <= r_err_cnt + 16'd1;
      end
   end

   assign frame_cnt = r_frame_cnt;
   assign err_cnt   = r_err_cnt;
`else
   assign frame_cnt = 16'h0000;
   assign err_cnt   = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_detector_filter.sv
// ============================================================================
// tb_detector_filter : directed self-checking bench for detector_filter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_detector_filter;

`ifdef DETECTOR_FILTER_STATS_EN
   localparam logic [15:0] C_EXP_FRAMES = 16'd5;
   localparam logic [15:0] C_EXP_ERRS   = 16'd2;
`else
   localparam logic [15:0] C_EXP_FRAMES = 16'd0;
   localparam logic [15:0] C_EXP_ERRS   = 16'd0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rec_byte;
   logic        rec_valid;
   logic [3:0]  det_stable;
   logic [3:0]  det_rise;
   logic [3:0]  det_fall;
   logic        link_ok;
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   detector_filter #(
      .FRAME_HDR   (4'b0000),
      .STABLE_CNT  (3),
      .TIMEOUT_CYC (1000),
      .ERR_LIMIT   (4)
   ) dut (
      .sys_clk    (clk),
      .rst        (rst),
      .rec_byte   (rec_byte),
      .rec_valid  (rec_valid),
      .det_stable (det_stable),
      .det_rise   (det_rise),
      .det_fall   (det_fall),
      .link_ok    (link_ok),
      .frame_cnt  (frame_cnt),
      .err_cnt    (err_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic send(input logic [7:0] b);
      rec_byte  = b;
      rec_valid = 1'b1;
      tick();
      rec_valid = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; rec_byte = 8'h00; rec_valid = 1'b0;
      idle(2);
      rst = 1'b0;
      chk("rst_stable", 16'(det_stable), 16'hF);
      chk("rst_rise",   16'(det_rise),   16'h0);
      chk("rst_fall",   16'(det_fall),   16'h0);
      chk("rst_link",   16'(link_ok),    16'h0);
      chk("rst_frames", frame_cnt,       16'h0);
      chk("rst_errs",   err_cnt,         16'h0);

      // Bring-up with three spaced frames
      send(8'h05); idle(99);
      send(8'h05); idle(99);
      send(8'h05);
      chk("up_link_pre",   16'(link_ok),    16'h0);
      chk("up_stable_pre", 16'(det_stable), 16'hF);
      tick();
      chk("up_link",   16'(link_ok),    16'h1);
      chk("up_stable", 16'(det_stable), 16'h5);
      chk("up_fall",   16'(det_fall),   16'hA);
      chk("up_rise",   16'(det_rise),   16'h0);
      tick();
      chk("up_fall_end", 16'(det_fall), 16'h0);

      // Bouncing bit0 commits only after three matching frames
      send(8'h04); send(8'h05); send(8'h04); send(8'h04);
      chk("deb_hold4", 16'(det_stable), 16'h5);
      send(8'h04);
      chk("deb_hold5", 16'(det_stable), 16'h5);
      tick();
      chk("deb_stable", 16'(det_stable), 16'h4);
      chk("deb_fall",   16'(det_fall),   16'h1);
      tick();
      chk("deb_fall_end", 16'(det_fall), 16'h0);

      // Timeout: exactly 1000 cycles after the last valid frame
      send(8'h04);
      idle(999);
      chk("to_link_pre", 16'(link_ok), 16'h1);
      tick();
      chk("to_link",   16'(link_ok),    16'h0);
      chk("to_stable", 16'(det_stable), 16'hF);
      chk("to_rise",   16'(det_rise),   16'hB);

      // Re-sync, then a valid frame on the expiry cycle keeps the link
      send(8'h04); send(8'h04); send(8'h04);
      tick();
      chk("resync_link", 16'(link_ok),  16'h1);
      chk("resync_fall", 16'(det_fall), 16'hB);
      idle(998);
      send(8'h04);
      chk("expiry_frame_link", 16'(link_ok), 16'h1);
      idle(5);
      chk("expiry_frame_link2", 16'(link_ok), 16'h1);

      // Four bad headers drop the link
      send(8'hA5); send(8'hA5); send(8'hA5);
      chk("bad3_link",   16'(link_ok),    16'h1);
      chk("bad3_stable", 16'(det_stable), 16'h4);
      send(8'hA5);
      chk("bad4_link",   16'(link_ok),    16'h0);
      chk("bad4_stable", 16'(det_stable), 16'hF);
      chk("bad4_rise",   16'(det_rise),   16'hB);

      // A valid frame breaks the bad-header run
      send(8'h05); send(8'h05); send(8'h05);
      tick();
      chk("up2_stable", 16'(det_stable), 16'h5);
      send(8'hA5); send(8'hA5); send(8'hA5);
      send(8'h05);
      send(8'hA5); send(8'hA5); send(8'hA5);
      chk("run_link",   16'(link_ok),    16'h1);
      chk("run_stable", 16'(det_stable), 16'h5);

      // Drop, enter SYNC, then reset while a frame is strobed
      send(8'hA5);
      chk("drop_rise", 16'(det_rise), 16'hA);
      send(8'h05);
      chk("sync_link", 16'(link_ok), 16'h0);
      rst = 1'b1; rec_byte = 8'h05; rec_valid = 1'b1;
      tick();
      rst = 1'b0; rec_valid = 1'b0;
      chk("mrst_stable", 16'(det_stable), 16'hF);
      chk("mrst_rise",   16'(det_rise),   16'h0);
      chk("mrst_fall",   16'(det_fall),   16'h0);
      chk("mrst_link",   16'(link_ok),    16'h0);
      chk("mrst_frames", frame_cnt,       16'h0);
      chk("mrst_errs",   err_cnt,         16'h0);
      send(8'h05); send(8'h05);
      tick();
      chk("mrst_ignored", 16'(link_ok), 16'h0);

      // Statistics: five valid and two bad frames since reset
      send(8'h05); send(8'h05); send(8'h05);
      send(8'hA5); send(8'hA5);
      tick();
      chk("stats_link",   16'(link_ok), 16'h1);
      chk("stats_frames", frame_cnt,    C_EXP_FRAMES);
      chk("stats_errs",   err_cnt,      C_EXP_ERRS);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
